// File: rtl/leds_output_pio_if.sv
// Avalon-MM slave bus bundle for the LED output PIO.
// The master modport is the CPU/interconnect side; the slave modport is the PIO side.
interface leds_output_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/leds_output_pio.sv
// Avalon-MM output PIO with set/clear registers and an optional blink mask.
// Blink prescaler, phase and BLINK_MASK register exist only when LEDS_OUTPUT_PIO_BLINK_EN is defined.
module leds_output_pio #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          BLINK_DIV   = 25000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  leds_output_pio_if.slave     bus,
  output logic [WIDTH-1:0]     out_port
);

  localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];

  logic             we;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] out_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] blink_bits;
  logic [WIDTH-1:0] mask_rd;
  logic             unused_writedata;

  assign we               = bus.chipselect & ~bus.write_n;
  assign wd               = bus.writedata[WIDTH-1:0];
  assign unused_writedata = ^bus.writedata;

`ifdef LEDS_OUTPUT_PIO_BLINK_EN
  localparam int CW = $clog2(BLINK_DIV);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [WIDTH-1:0] mask_q, mask_d;

  // Free-running prescaler; bus writes never touch the counter or the phase.
  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    phase_d = phase_q;
    mask_d  = mask_q;
    if (cnt_q == CW'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
    if (we && bus.address == 2'd3) mask_d = wd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      mask_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      mask_q  <= mask_d;
    end
  end

  assign blink_bits = mask_q & {WIDTH{phase_q}};
  assign mask_rd    = mask_q;
`else
  assign blink_bits = '0;
  assign mask_rd    = '0;
`endif

  always_comb begin
    data_d = data_q;
    if (we) begin
      unique case (bus.address)
        2'd0:    data_d = wd;
        2'd1:    data_d = data_q | wd;
        2'd2:    data_d = data_q & ~wd;
        default: data_d = data_q;
      endcase
    end
  end

  // Read mux samples pre-write state, so a same-cycle write reads back the old value.
  always_comb begin
    readdata_d = '0;
    unique case (bus.address)
      2'd3:    readdata_d[WIDTH-1:0] = mask_rd;
      default: readdata_d[WIDTH-1:0] = data_q;
    endcase
  end

  assign out_d = data_q ^ blink_bits;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RST_V;
      out_port   <= RST_V;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      out_port   <= out_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_leds_output_pio.sv
// Self-checking bench for leds_output_pio against a cycle-count based reference model.
// Expectations follow LEDS_OUTPUT_PIO_BLINK_EN as seen by this compile.
module tb_leds_output_pio;

  localparam int          WIDTH       = 8;
  localparam logic [31:0] RESET_VALUE = 32'h0;
  localparam int          BLINK_DIV   = 4;
`ifdef LEDS_OUTPUT_PIO_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] out_port;

  leds_output_pio_if bus();

  leds_output_pio #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE), .BLINK_DIV(BLINK_DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: register contents plus the number of edges since reset release.
  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] m_mask;
  int               m_edges;
  logic [WIDTH-1:0] exp_out;
  logic [31:0]      exp_rd;

  function automatic logic phase_after(input int edges);
    return BLINK ? (((edges / BLINK_DIV) % 2) == 1) : 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    if (a == 2'd3) r[WIDTH-1:0] = BLINK ? m_mask : '0;
    else           r[WIDTH-1:0] = m_data;
    return r;
  endfunction

  task automatic model_reset();
    m_data  = RESET_VALUE[WIDTH-1:0];
    m_mask  = '0;
    m_edges = 0;
    exp_out = RESET_VALUE[WIDTH-1:0];
    exp_rd  = '0;
  endtask

  // Drives one bus cycle from the negedge, advances the model at the posedge, returns at the next negedge.
  task automatic cycle(input logic cs, input logic wr, input logic [1:0] a, input logic [31:0] wdat);
    logic [WIDTH-1:0] w;
    bus.chipselect = cs;
    bus.write_n    = ~wr;
    bus.address    = a;
    bus.writedata  = wdat;
    @(posedge clk);
    w       = wdat[WIDTH-1:0];
    exp_out = m_data ^ (m_mask & {WIDTH{phase_after(m_edges)}});
    exp_rd  = model_read(a);
    if (cs && wr) begin
      case (a)
        2'd0: m_data = w;
        2'd1: m_data = m_data | w;
        2'd2: m_data = m_data & ~w;
        2'd3: if (BLINK) m_mask = w;
      endcase
    end
    m_edges++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = '0;
    reset_n        = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (out_port !== RESET_VALUE[WIDTH-1:0]) begin
      failures++;
      $display("[TB] FAIL reset_out_port: got %h expected %h", out_port, RESET_VALUE[WIDTH-1:0]);
    end
    checks++;
    if (bus.readdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_readdata: got %h expected %h", bus.readdata, 32'h0);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_data_write();
    cycle(1'b1, 1'b1, 2'd0, 32'h0000_00A5);
    checks++;
    if (out_port !== 8'h00) begin
      failures++;
      $display("[TB] FAIL data_out_lag: got %h expected %h", out_port, 8'h00);
    end
    cycle(1'b1, 1'b0, 2'd0, 32'h0);
    checks++;
    if (out_port !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL data_out: got %h expected %h", out_port, 8'hA5);
    end
    checks++;
    if (bus.readdata !== 32'h0000_00A5) begin
      failures++;
      $display("[TB] FAIL data_read: got %h expected %h", bus.readdata, 32'h0000_00A5);
    end
  endtask

  task automatic test_set_clear();
    logic [1:0]  addrs [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
    logic        wrs   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] wds   [4] = '{32'h0F, 32'h81, 32'h0, 32'h0};
    logic [7:0]  outs  [4] = '{8'hA5, 8'hAF, 8'h2E, 8'h2E};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, wrs[i], addrs[i], wds[i]);
      checks++;
      if (out_port !== outs[i]) begin
        failures++;
        $display("[TB] FAIL setclr_out[%0d]: got %h expected %h", i, out_port, outs[i]);
      end
      if (i >= 2) begin
        checks++;
        if (bus.readdata !== 32'h0000_002E) begin
          failures++;
          $display("[TB] FAIL setclr_read[%0d]: got %h expected %h", i, bus.readdata, 32'h2E);
        end
      end
    end
  endtask

  task automatic test_blink();
    logic [WIDTH-1:0] prev;
    int run;
    int runs_seen;
    cycle(1'b1, 1'b1, 2'd0, 32'h0);
    cycle(1'b1, 1'b1, 2'd3, 32'h3);
    cycle(1'b0, 1'b0, 2'd3, 32'h0);
    prev = out_port;
    run  = 1;
    runs_seen = 0;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b0, 1'b0, 2'd3, 32'h0);
      checks++;
      if (out_port !== exp_out) begin
        failures++;
        $display("[TB] FAIL blink_out[%0d]: got %h expected %h", i, out_port, exp_out);
      end
      checks++;
      if (bus.readdata !== (BLINK ? 32'h3 : 32'h0)) begin
        failures++;
        $display("[TB] FAIL blink_read[%0d]: got %h expected %h", i, bus.readdata, BLINK ? 32'h3 : 32'h0);
      end
      if (out_port === prev) run++;
      else begin
        if (runs_seen > 0) begin
          checks++;
          if (run != BLINK_DIV) begin
            failures++;
            $display("[TB] FAIL blink_hold: got %0d cycles expected %0d", run, BLINK_DIV);
          end
        end
        runs_seen++;
        run  = 1;
        prev = out_port;
      end
    end
    checks++;
    if ((runs_seen >= 4) !== BLINK) begin
      failures++;
      $display("[TB] FAIL blink_toggles: got %0d changes expected blinking=%0d", runs_seen, BLINK);
    end
  endtask

  task automatic test_reset_mid();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_port !== RESET_VALUE[WIDTH-1:0]) begin
      failures++;
      $display("[TB] FAIL midreset_out: got %h expected %h", out_port, RESET_VALUE[WIDTH-1:0]);
    end
    checks++;
    if (bus.readdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL midreset_read: got %h expected %h", bus.readdata, 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 2'd3, 32'h0);
      checks++;
      if (out_port !== 8'h00 || bus.readdata !== 32'h0) begin
        failures++;
        $display("[TB] FAIL postreset[%0d]: got out=%h rd=%h expected out=00 rd=0", i, out_port, bus.readdata);
      end
    end
  endtask

  task automatic test_wide_write();
    cycle(1'b1, 1'b1, 2'd0, 32'hFFFF_FF3C);
    cycle(1'b1, 1'b0, 2'd0, 32'h0);
    checks++;
    if (out_port !== 8'h3C) begin
      failures++;
      $display("[TB] FAIL wide_out: got %h expected %h", out_port, 8'h3C);
    end
    checks++;
    if (bus.readdata !== 32'h0000_003C) begin
      failures++;
      $display("[TB] FAIL wide_read: got %h expected %h", bus.readdata, 32'h3C);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
            2'($urandom_range(0, 3)), $urandom);
      checks++;
      if (out_port !== exp_out || bus.readdata !== exp_rd) begin
        failures++;
        $display("[TB] FAIL random[%0d]: got out=%h rd=%h expected out=%h rd=%h",
                 i, out_port, bus.readdata, exp_out, exp_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_set_clear();
    test_blink();
    test_reset_mid();
    test_wide_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
